// File: rtl/rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// rr_grant_scheduler
//
// Round-robin arbiter that shares one engine port among 32 requesters.
// Requests are masked to the indices below the previous winner. The highest
// set bit of that masked vector wins. If the masked vector is empty, the
// highest set bit of the raw request vector wins instead. Once granted, the
// owner keeps the resource until it asserts i_release. At least one idle cycle
// always separates two grants.
//
// Optional feature (compile-time macro RRS_WATCHDOG_EN):
//   A hold watchdog forces a release after TIMEOUT_CYC cycles in BUSY and
//   pulses o_timeout for one cycle. Without the macro, o_timeout is tied 0
//   and a grant is held indefinitely.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   i_req        in   32     request vector, bit k = requester k
//   i_release    in   1      owner done; only looked at while BUSY
//   o_gnt_valid  out  1      grant active
//   o_gnt        out  32     one-hot grant, zero when idle
//   o_gnt_idx    out  5      granted index, holds last value when idle
//   o_timeout    out  1      one-cycle pulse on watchdog-forced release
// -----------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int N_REQ       = 32,
    parameter int IDX_W       = $clog2(N_REQ),
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_release,
    output logic             o_gnt_valid,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_timeout
);

    // Elaboration-time sanity checks on the configuration.
    if (N_REQ != 32) begin : g_bad_nreq
        $error("rr_grant_scheduler: N_REQ must be 32");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("rr_grant_scheduler: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] win;
    logic             force_rel;

    // Returns the index of the highest set bit (0 when v is empty).
    function automatic logic [IDX_W-1:0] find_max(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (v[k]) r = IDX_W'(k);
        end
        return r;
    endfunction

    // Only indices strictly below the last winner are eligible first. This
    // gives descending rotation k-1 ... 0, then wrap to the top.
    assign mask   = (N_REQ'(1) << ptr_q) - N_REQ'(1);
    assign masked = i_req & mask;
    assign cand   = (masked != '0) ? masked : i_req;
    assign win    = find_max(cand);

`ifdef RRS_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q;

    // A release in the same cycle takes precedence and suppresses the pulse.
    assign force_rel = (state_q == BUSY) && !i_release &&
                       (hold_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == IDLE) begin
            hold_cnt_d = '0;
        end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= force_rel;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|i_req) begin
                    state_d = BUSY;
                    gnt_d   = N_REQ'(1) << win;
                    idx_d   = win;
                    ptr_d   = win;
                end
            end
            BUSY: begin
                // Request changes are ignored while a grant is held.
                if (i_release || force_rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_gnt_valid = (state_q == BUSY);
    assign o_gnt       = gnt_q;
    assign o_gnt_idx   = idx_q;

endmodule
